// File: rtl/riscv_muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding and a small decode helper.
package riscv_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/riscv_muldiv_unit_if.sv
// Request/response handshake bundle between the execute stage and the muldiv unit.
interface riscv_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic            busy;

  modport master (
    output in_valid, op, op1, op2, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, op, op1, op2, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/riscv_muldiv_unit_div_step.sv
// Combinational restoring-division step: shifts in one dividend bit,
// trial-subtracts the divisor and produces one quotient bit.
module riscv_muldiv_unit_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0] trial_s;
  logic [XLEN:0] diff_s;
  logic          ge_s;

  // Trial subtract; rem_in < divisor keeps the restored value within XLEN bits.
  always_comb begin
    trial_s = {rem_in, quo_in[XLEN-1]};
    diff_s  = trial_s - {1'b0, divisor};
    ge_s    = (trial_s >= {1'b0, divisor});
    if (ge_s) begin
      rem_out = diff_s[XLEN-1:0];
    end else begin
      rem_out = trial_s[XLEN-1:0];
    end
    quo_out = {quo_in[XLEN-2:0], ge_s};
  end
endmodule

// File: rtl/riscv_muldiv_unit.sv
// Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Iterative shift-add multiply and restoring divide on magnitudes, sign fixed afterwards.
module riscv_muldiv_unit
  import riscv_muldiv_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input logic                clk,
  input logic                rst,
  riscv_muldiv_unit_if.slave bus
);
  localparam int                CW       = $clog2(XLEN);
  localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0]   ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ZERO2    = {(2*XLEN){1'b0}};

  md_state_e         state_r;
  funct3_e           op_r;
  logic [CW-1:0]     cnt_r;
  logic              neg_r;
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   a_r;
  logic [XLEN-1:0]   b_r;
  logic [XLEN-1:0]   res_r;
  logic              out_valid_r;
  logic              busy_r;

  funct3_e           op_s;
  logic              in_ready_s, accept_s, sgn1_s, sgn2_s, neg_s, special_s;
  logic [XLEN-1:0]   mag1_s, mag2_s, special_res_s, fast_res_s, fix_res_s;
  logic [XLEN-1:0]   rem_step_s, quo_step_s;
  logic [2*XLEN-1:0] fast_mag_s, fast_prod_s, acc_neg_s, acc_step_s;
  logic [XLEN:0]     mul_sum_s;

  assign in_ready_s    = (state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.out_ready);
  assign accept_s      = bus.in_valid && in_ready_s;
  assign op_s          = funct3_e'(bus.op);
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.res       = res_r;
  assign bus.busy      = busy_r;

  // Accept-time decode: operand signs, magnitudes, result sign and special cases.
  always_comb begin
    case (op_s)
      F3_MULH, F3_DIV, F3_REM: begin
        sgn1_s = bus.op1[XLEN-1];
        sgn2_s = bus.op2[XLEN-1];
      end
      F3_MULHSU: begin
        sgn1_s = bus.op1[XLEN-1];
        sgn2_s = 1'b0;
      end
      default: begin
        sgn1_s = 1'b0;
        sgn2_s = 1'b0;
      end
    endcase
    if (sgn1_s) mag1_s = ZERO - bus.op1; else mag1_s = bus.op1;
    if (sgn2_s) mag2_s = ZERO - bus.op2; else mag2_s = bus.op2;
    // Remainders follow the dividend sign; products and quotients the sign product.
    if ((op_s == F3_REM) || (op_s == F3_REMU)) neg_s = sgn1_s; else neg_s = sgn1_s ^ sgn2_s;
    if (is_div(op_s) && (bus.op2 == ZERO)) begin
      special_s = 1'b1;
      if (op_s[1]) special_res_s = bus.op1; else special_res_s = ALL_ONES;
    end else if (((op_s == F3_DIV) || (op_s == F3_REM)) && (bus.op1 == INT_MIN) && (bus.op2 == ALL_ONES)) begin
      special_s = 1'b1;
      if (op_s == F3_REM) special_res_s = ZERO; else special_res_s = bus.op1;
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO;
    end
    fast_mag_s = {ZERO, mag1_s} * {ZERO, mag2_s};
    if (neg_s) fast_prod_s = ZERO2 - fast_mag_s; else fast_prod_s = fast_mag_s;
    if (op_s == F3_MUL) fast_res_s = fast_prod_s[XLEN-1:0]; else fast_res_s = fast_prod_s[2*XLEN-1:XLEN];
  end

  riscv_muldiv_unit_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (acc_r[2*XLEN-1:XLEN]),
    .quo_in  (acc_r[XLEN-1:0]),
    .divisor (b_r),
    .rem_out (rem_step_s),
    .quo_out (quo_step_s)
  );

  // One iteration: multiply adds into the high half and shifts right; divide uses the step.
  always_comb begin
    if (acc_r[0]) mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, a_r};
    else          mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
    if (is_div(op_r)) acc_step_s = {rem_step_s, quo_step_s};
    else              acc_step_s = {mul_sum_s, acc_r[XLEN-1:1]};
  end

  // Sign correction and half selection for the finished accumulator.
  always_comb begin
    acc_neg_s = ZERO2 - acc_r;
    case (op_r)
      F3_MUL:                       fix_res_s = neg_r ? acc_neg_s[XLEN-1:0] : acc_r[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res_s = neg_r ? acc_neg_s[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res_s = neg_r ? (ZERO - acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
      F3_REM, F3_REMU:              fix_res_s = neg_r ? (ZERO - acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
      default:                      fix_res_s = ZERO;
    endcase
  end

  // Control FSM with registered result, out_valid and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      op_r        <= F3_MUL;
      cnt_r       <= {CW{1'b0}};
      neg_r       <= 1'b0;
      acc_r       <= ZERO2;
      a_r         <= ZERO;
      b_r         <= ZERO;
      res_r       <= ZERO;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            op_r   <= op_s;
            a_r    <= mag1_s;
            b_r    <= mag2_s;
            neg_r  <= neg_s;
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b1;
            if (is_div(op_s)) acc_r <= {ZERO, mag1_s}; else acc_r <= {ZERO, mag2_s};
            if (special_s) begin
              res_r       <= special_res_s;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else if (FAST_MUL && !is_div(op_s)) begin
              res_r       <= fast_res_s;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              out_valid_r <= 1'b0;
              state_r     <= ST_CALC;
            end
          end else if ((state_r == ST_DONE) && bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) state_r <= ST_FIX;
        end
        ST_FIX: begin
          res_r       <= fix_res_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed self-checking bench for riscv_muldiv_unit: iterative (dut_it) and fast-multiply (dut_fm) builds.
module tb_riscv_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  riscv_muldiv_unit_if #(.XLEN(32)) bus_it ();
  riscv_muldiv_unit_if #(.XLEN(32)) bus_fm ();

  riscv_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) dut_it (.clk(clk), .rst(rst), .bus(bus_it));
  riscv_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) dut_fm (.clk(clk), .rst(rst), .bus(bus_fm));

  always #5 clk = ~clk;

  // Issue one op from a negedge with out_ready=1; returns result and accept-to-valid latency.
  task automatic do_op(input bit fast, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat);
    logic ov;
    if (fast) begin
      bus_fm.op = op; bus_fm.op1 = a; bus_fm.op2 = b; bus_fm.in_valid = 1'b1;
    end else begin
      bus_it.op = op; bus_it.op1 = a; bus_it.op2 = b; bus_it.in_valid = 1'b1;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus_it.in_valid = 1'b0;
    bus_fm.in_valid = 1'b0;
    ov = fast ? bus_fm.out_valid : bus_it.out_valid;
    while (!ov && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      ov = fast ? bus_fm.out_valid : bus_it.out_valid;
    end
    r = fast ? bus_fm.res : bus_it.res;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus_it.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b want=0", bus_it.out_valid); end
    total++; if (bus_it.res !== 32'h0) begin bad++; $display("FAIL reset res got=%h want=00000000", bus_it.res); end
    total++; if (bus_it.busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", bus_it.busy); end
    total++; if (bus_it.in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%b want=1", bus_it.in_ready); end
    total++; if (bus_fm.out_valid !== 1'b0) begin bad++; $display("FAIL reset fm out_valid got=%b want=0", bus_fm.out_valid); end
  endtask

  task automatic test_iterative();
    vec_t        v [9];
    logic [31:0] r;
    int          lat;
    v[0] = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    v[1] = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 34};
    v[2] = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    v[3] = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    v[4] = '{3'd0, 32'd6,          32'd7,        32'd42,       34};
    v[5] = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34};
    v[6] = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34};
    v[7] = '{3'd5, 32'hFFFFFFFF,   32'd2,        32'h7FFFFFFF, 34};
    v[8] = '{3'd7, 32'hFFFFFFFF,   32'd2,        32'h00000001, 34};
    for (int i = 0; i < 9; i++) begin
      do_op(1'b0, v[i].op, v[i].a, v[i].b, r, lat);
      total++; if (r !== v[i].exp) begin bad++; $display("FAIL iter[%0d] res got=%h want=%h", i, r, v[i].exp); end
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL iter[%0d] latency got=%0d want=%0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_special();
    vec_t        v [5];
    logic [31:0] r;
    int          lat;
    v[0] = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    v[1] = '{3'd6, 32'd5,        32'd0,        32'h00000005, 1};
    v[2] = '{3'd5, 32'd0,        32'd0,        32'hFFFFFFFF, 1};
    v[3] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    v[4] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, v[i].op, v[i].a, v[i].b, r, lat);
      total++; if (r !== v[i].exp) begin bad++; $display("FAIL special[%0d] res got=%h want=%h", i, r, v[i].exp); end
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL special[%0d] latency got=%0d want=%0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus_it.out_ready = 1'b0;
    bus_it.op = 3'd5; bus_it.op1 = 32'd100; bus_it.op2 = 32'd7; bus_it.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus_it.in_valid = 1'b0;
    while (!bus_it.out_valid && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    total++; if (lat !== 34) begin bad++; $display("FAIL bp latency got=%0d want=34", lat); end
    for (int i = 0; i < 10; i++) begin
      total++; if (bus_it.out_valid !== 1'b1) begin bad++; $display("FAIL bp hold[%0d] out_valid got=%b want=1", i, bus_it.out_valid); end
      total++; if (bus_it.res !== 32'd14) begin bad++; $display("FAIL bp hold[%0d] res got=%h want=0000000e", i, bus_it.res); end
      total++; if (bus_it.in_ready !== 1'b0) begin bad++; $display("FAIL bp hold[%0d] in_ready got=%b want=0", i, bus_it.in_ready); end
      @(posedge clk);
      @(negedge clk);
    end
    // Release with a new iterative op in the same cycle: accepted, out_valid drops.
    bus_it.op = 3'd0; bus_it.op1 = 32'd3; bus_it.op2 = 32'd5; bus_it.in_valid = 1'b1;
    bus_it.out_ready = 1'b1;
    #1;
    total++; if (bus_it.in_ready !== 1'b1) begin bad++; $display("FAIL handoff in_ready got=%b want=1", bus_it.in_ready); end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus_it.in_valid = 1'b0;
    total++; if (bus_it.out_valid !== 1'b0) begin bad++; $display("FAIL handoff out_valid got=%b want=0", bus_it.out_valid); end
    total++; if (bus_it.busy !== 1'b1) begin bad++; $display("FAIL handoff busy got=%b want=1", bus_it.busy); end
    while (!bus_it.out_valid && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    total++; if (lat !== 34) begin bad++; $display("FAIL handoff latency got=%0d want=34", lat); end
    total++; if (bus_it.res !== 32'd15) begin bad++; $display("FAIL handoff res got=%h want=0000000f", bus_it.res); end
    // Special-case op handed off in DONE keeps out_valid high with the new result.
    bus_it.op = 3'd4; bus_it.op1 = 32'd5; bus_it.op2 = 32'd0; bus_it.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_it.in_valid = 1'b0;
    total++; if (bus_it.out_valid !== 1'b1) begin bad++; $display("FAIL b2b special out_valid got=%b want=1", bus_it.out_valid); end
    total++; if (bus_it.res !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b special res got=%h want=ffffffff", bus_it.res); end
    @(posedge clk);
    @(negedge clk);
    total++; if (bus_it.out_valid !== 1'b0) begin bad++; $display("FAIL b2b retire out_valid got=%b want=0", bus_it.out_valid); end
    total++; if (bus_it.busy !== 1'b0) begin bad++; $display("FAIL b2b retire busy got=%b want=0", bus_it.busy); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    int          lat;
    bit          seen;
    bus_it.op = 3'd4; bus_it.op1 = 32'd100; bus_it.op2 = 32'd7; bus_it.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_it.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus_it.out_valid !== 1'b0) begin bad++; $display("FAIL abort out_valid got=%b want=0", bus_it.out_valid); end
    total++; if (bus_it.in_ready !== 1'b1) begin bad++; $display("FAIL abort in_ready got=%b want=1", bus_it.in_ready); end
    total++; if (bus_it.busy !== 1'b0) begin bad++; $display("FAIL abort busy got=%b want=0", bus_it.busy); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_it.out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort stale result got=%b want=0", seen); end
    do_op(1'b0, 3'd0, 32'd6, 32'd7, r, lat);
    total++; if (r !== 32'd42) begin bad++; $display("FAIL abort mul res got=%h want=0000002a", r); end
    total++; if (lat !== 34) begin bad++; $display("FAIL abort mul latency got=%0d want=34", lat); end
  endtask

  task automatic test_fast_mul();
    vec_t        v [4];
    logic [31:0] r;
    int          lat;
    v[0] = '{3'd0, 32'd6,        32'd7,        32'd42,       1};
    v[1] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1};
    v[2] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1};
    v[3] = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, v[i].op, v[i].a, v[i].b, r, lat);
      total++; if (r !== v[i].exp) begin bad++; $display("FAIL fast[%0d] res got=%h want=%h", i, r, v[i].exp); end
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL fast[%0d] latency got=%0d want=%0d", i, lat, v[i].lat); end
    end
  endtask

  initial begin
    bus_it.in_valid = 1'b0; bus_it.op = 3'd0; bus_it.op1 = 32'd0; bus_it.op2 = 32'd0; bus_it.out_ready = 1'b1;
    bus_fm.in_valid = 1'b0; bus_fm.op = 3'd0; bus_fm.op1 = 32'd0; bus_fm.op2 = 32'd0; bus_fm.out_ready = 1'b1;
    test_reset();
    test_iterative();
    test_special();
    test_backpressure();
    test_reset_abort();
    test_fast_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
